// File: rtl/pg_rail_sequencer.sv
// Two-rail power-up/power-down sequencer for a single power domain.
// Rail A ramps before rail B; power-down runs in reverse. pg is the domain-good indication.
module pg_rail_sequencer #(
  parameter int unsigned TIMEOUT_CYC  = 1000,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwr_req,
  input  logic       good_a,
  input  logic       good_b,
  output logic       en_a,
  output logic       en_b,
  output logic       pg,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StOff    = 3'd0,
    StRampA  = 3'd1,
    StRampB  = 3'd2,
    StSettle = 3'd3,
    StOn     = 3'd4,
    StDownB  = 3'd5,
    StDownA  = 3'd6,
    StFault  = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] TimeoutLast  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] DebounceLast = CNT_W'(DEBOUNCE_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_a_d, en_b_d, pg_d, fault_d;
  logic             timeout, settled, both_good;

  assign timeout   = (cnt_q == TimeoutLast);
  assign settled   = (cnt_q == DebounceLast);
  assign both_good = good_a & good_b;

  // Branch order inside each state encodes priority: faults beat pwr_req deassertion,
  // and a good_x rise on the timeout cycle counts as success.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOff: begin
        if (pwr_req) state_d = StRampA;
      end
      StRampA: begin
        if (good_a)        state_d = StRampB;
        else if (timeout)  state_d = StFault;
        else if (!pwr_req) state_d = StDownA;
      end
      StRampB: begin
        if (!good_a)       state_d = StFault;
        else if (good_b)   state_d = StSettle;
        else if (timeout)  state_d = StFault;
        else if (!pwr_req) state_d = StDownB;
      end
      StSettle: begin
        if (!both_good)    state_d = StFault;
        else if (!pwr_req) state_d = StDownB;
        else if (settled)  state_d = StOn;
      end
      StOn: begin
        if (!both_good)    state_d = StFault;
        else if (!pwr_req) state_d = StDownB;
      end
      StDownB: begin
        // A stuck-high good_b only delays power-down; it is not a fault.
        if (!good_b || timeout) state_d = StDownA;
      end
      StDownA: begin
        if (!good_a || timeout) state_d = StOff;
      end
      StFault: begin
        if (!pwr_req) state_d = StOff;
      end
      default: state_d = StFault;
    endcase
  end

  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Outputs decode the next state so they register alongside it.
  always_comb begin
    en_a_d  = 1'b0;
    en_b_d  = 1'b0;
    pg_d    = 1'b0;
    fault_d = 1'b0;
    unique case (state_d)
      StOff:    ;
      StRampA:  en_a_d = 1'b1;
      StRampB:  begin en_a_d = 1'b1; en_b_d = 1'b1; end
      StSettle: begin en_a_d = 1'b1; en_b_d = 1'b1; end
      StOn:     begin en_a_d = 1'b1; en_b_d = 1'b1; pg_d = 1'b1; end
      StDownB:  en_a_d = 1'b1;
      StDownA:  ;
      StFault:  fault_d = 1'b1;
      default:  fault_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StOff;
      cnt_q   <= '0;
      en_a    <= 1'b0;
      en_b    <= 1'b0;
      pg      <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_a    <= en_a_d;
      en_b    <= en_b_d;
      pg      <= pg_d;
      fault   <= fault_d;
    end
  end

  assign state = state_q;

  a_en_order:  assert property (@(posedge clk) en_b |-> en_a);
  a_pg_rails:  assert property (@(posedge clk) pg |-> (en_a && en_b));
  a_fault_off: assert property (@(posedge clk) fault |-> (!en_a && !en_b && !pg));

endmodule

// File: tb/tb_pg_rail_sequencer.sv
// Directed scoreboard bench for pg_rail_sequencer (TIMEOUT_CYC=100, DEBOUNCE_CYC=4).
// The stimulus queues the expected state per clock; a monitor checks it after each edge.
module tb_pg_rail_sequencer;

  localparam logic [2:0] OFF = 3'd0, RAMP_A = 3'd1, RAMP_B = 3'd2, SETTLE = 3'd3;
  localparam logic [2:0] ON = 3'd4, DOWN_B = 3'd5, DOWN_A = 3'd6, FLT = 3'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwr_req = 1'b0;
  logic       good_a = 1'b0;
  logic       good_b = 1'b0;
  logic       en_a, en_b, pg, fault;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] exp_q[$];
  string      tag_q[$];

  pg_rail_sequencer #(
    .TIMEOUT_CYC (100),
    .DEBOUNCE_CYC(4),
    .CNT_W       (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .pwr_req(pwr_req),
    .good_a (good_a),
    .good_b (good_b),
    .en_a   (en_a),
    .en_b   (en_b),
    .pg     (pg),
    .fault  (fault),
    .state  (state)
  );

  always #5 clk = ~clk;

  // {en_a, en_b, pg, fault} for each state.
  function automatic logic [3:0] outs_for(input logic [2:0] s);
    case (s)
      RAMP_A:         return 4'b1000;
      RAMP_B, SETTLE: return 4'b1100;
      ON:             return 4'b1110;
      DOWN_B:         return 4'b1000;
      FLT:            return 4'b0001;
      default:        return 4'b0000;
    endcase
  endfunction

  // Drive inputs for n clocks; expected state is the one visible after each of those edges.
  task automatic cyc(input logic r, input logic q, input logic a, input logic b,
                     input logic [2:0] s, input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst     = r;
      pwr_req = q;
      good_a  = a;
      good_b  = b;
      exp_q.push_back(s);
      tag_q.push_back(tag);
    end
  endtask

  task automatic power_up(input string tag);
    cyc(0, 1, 0, 0, RAMP_A, tag, 1);
    cyc(0, 1, 1, 0, RAMP_B, tag, 1);
    cyc(0, 1, 1, 1, SETTLE, tag, 4);
    cyc(0, 1, 1, 1, ON,     tag, 1);
  endtask

  logic [2:0] m_exp;
  string      m_tag;
  logic [6:0] m_got, m_want;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      m_exp  = exp_q.pop_front();
      m_tag  = tag_q.pop_front();
      m_got  = {state, en_a, en_b, pg, fault};
      m_want = {m_exp, outs_for(m_exp)};
      n_checks++;
      if (m_got !== m_want) begin
        n_fail++;
        $display("FAIL %s @%0t: got state=%0d en_a=%b en_b=%b pg=%b fault=%b, expected state=%0d en_a/en_b/pg/fault=%b",
                 m_tag, $time, state, en_a, en_b, pg, fault, m_exp, outs_for(m_exp));
      end
    end
  end

  initial begin
    // Reset wins even with every input asserted.
    cyc(1, 1, 1, 1, OFF, "reset", 2);
    cyc(0, 0, 0, 0, OFF, "idle", 1);

    // 1: power-up timing from the reference sequence.
    cyc(0, 1, 0, 0, RAMP_A, "t1_ramp_a", 5);
    cyc(0, 1, 1, 0, RAMP_B, "t1_ramp_b", 5);
    cyc(0, 1, 1, 1, SETTLE, "t1_settle", 4);
    cyc(0, 1, 1, 1, ON,     "t1_on", 3);

    // 4: ordered power-down; pwr_req ignored in DOWN_A.
    cyc(0, 0, 1, 1, DOWN_B, "t4_down_b", 3);
    cyc(0, 0, 1, 0, DOWN_A, "t4_down_a", 1);
    cyc(0, 1, 1, 0, DOWN_A, "t4_req_ignored", 2);
    cyc(0, 0, 0, 0, OFF,    "t4_off", 2);

    // 4b: good_b stuck high, DOWN_B times out into DOWN_A without fault.
    power_up("t4b_up");
    cyc(0, 0, 1, 1, DOWN_B, "t4b_down_b_wait", 100);
    cyc(0, 0, 1, 1, DOWN_A, "t4b_down_b_timeout", 1);
    cyc(0, 0, 0, 1, OFF,    "t4b_off", 1);
    cyc(0, 0, 0, 0, OFF,    "t4b_idle", 1);

    // 2: ramp timeout exactly 100 clocks after en_a rises; held until pwr_req drops.
    cyc(0, 1, 0, 0, RAMP_A, "t2_ramp_a", 100);
    cyc(0, 1, 0, 0, FLT,    "t2_timeout", 4);
    cyc(0, 0, 0, 0, OFF,    "t2_clear", 2);

    // good_a rising on the timeout cycle is a success.
    cyc(0, 1, 0, 0, RAMP_A, "edge_ramp_a", 100);
    cyc(0, 1, 1, 0, RAMP_B, "edge_good_on_timeout", 1);
    cyc(0, 0, 1, 0, DOWN_B, "edge_abort_ramp_b", 1);
    cyc(0, 0, 1, 0, DOWN_A, "edge_down_a", 1);
    cyc(0, 0, 0, 0, OFF,    "edge_off", 1);

    // Abort in RAMP_A goes straight to DOWN_A.
    cyc(0, 1, 0, 0, RAMP_A, "abort_ramp_a", 2);
    cyc(0, 0, 0, 0, DOWN_A, "abort_down_a", 1);
    cyc(0, 0, 0, 0, OFF,    "abort_off", 1);

    // 3: single-cycle good_b loss in ON.
    power_up("t3_up");
    cyc(0, 1, 1, 0, FLT, "t3_loss", 1);
    cyc(0, 1, 1, 1, FLT, "t3_hold", 2);
    cyc(0, 0, 1, 1, OFF, "t3_clear", 1);
    cyc(0, 0, 0, 0, OFF, "t3_idle", 1);

    // Fault outranks a simultaneous pwr_req fall.
    power_up("prio_up");
    cyc(0, 0, 0, 1, FLT, "prio_fault_first", 1);
    cyc(0, 0, 0, 0, OFF, "prio_clear", 1);

    // Request drop during SETTLE.
    cyc(0, 1, 0, 0, RAMP_A, "settle_abort", 1);
    cyc(0, 1, 1, 0, RAMP_B, "settle_abort", 1);
    cyc(0, 1, 1, 1, SETTLE, "settle_abort", 2);
    cyc(0, 0, 1, 1, DOWN_B, "settle_abort_down_b", 1);
    cyc(0, 0, 0, 0, DOWN_A, "settle_abort_down_a", 1);
    cyc(0, 0, 0, 0, OFF,    "settle_abort_off", 1);

    // 5: good_a glitch at SETTLE cnt=2; pg never asserts.
    cyc(0, 1, 0, 0, RAMP_A, "t5_ramp_a", 1);
    cyc(0, 1, 1, 0, RAMP_B, "t5_ramp_b", 1);
    cyc(0, 1, 1, 1, SETTLE, "t5_settle", 3);
    cyc(0, 1, 0, 1, FLT,    "t5_glitch", 1);
    cyc(0, 1, 1, 1, FLT,    "t5_hold", 3);
    cyc(0, 0, 0, 0, OFF,    "t5_clear", 1);

    // 6: reset during RAMP_B with pwr_req still high.
    cyc(0, 1, 0, 0, RAMP_A, "t6_ramp_a", 1);
    cyc(0, 1, 1, 0, RAMP_B, "t6_ramp_b", 2);
    cyc(1, 1, 1, 0, OFF,    "t6_reset", 1);
    cyc(0, 1, 1, 0, RAMP_A, "t6_rerise", 1);
    cyc(0, 1, 1, 0, RAMP_B, "t6_ramp_b2", 1);
    cyc(0, 0, 1, 0, DOWN_B, "t6_down_b", 1);
    cyc(0, 0, 0, 0, DOWN_A, "t6_down_a", 1);
    cyc(0, 0, 0, 0, OFF,    "t6_off", 1);

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
